// File: rtl/rain_meter_tx.sv
// rain_meter_tx: measures the high time of one pulse per freq channel, scales
//   and saturates it to a rain value, and sends every channel as a UART-style frame on sd.
// Latency: freq -> channel FSM 2 cycles; first start bit 2 cycles after the last channel is DONE.
// Backpressure: none; en=0 freezes the channels, and a frame already in flight always completes.
//
// Optional feature macro: PARITY_EN (even parity over id+data, inserted before stop).
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-high
//   en           automatic-mode enable; 0 holds every channel where it is
//   finish_send  receiver restart: clear counts and ovf, re-arm channels, cut a round short
//   freq[N_CH]   raw asynchronous pulse inputs
//   sd           serial data, idle high
//   busy         frame transmission in progress
//   done         1-cycle pulse after the last channel's stop bit
//   ovf[N_CH]    sticky per-channel counter / value saturation flag

module rain_meter_tx #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 16,
  parameter int DATA_W   = 8,
  parameter int SHIFT    = 0,
  parameter int BAUD_DIV = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            finish_send,
  input  logic [N_CH-1:0] freq,
  output logic            sd,
  output logic            busy,
  output logic            done,
  output logic [N_CH-1:0] ovf
);

`ifdef PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // start + 3-bit id + data + optional parity + stop
  localparam int FRAME_W = 1 + 3 + DATA_W + PAR_W + 1;
  localparam int BAUD_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    CH_ARM,
    CH_WAIT_HI,
    CH_COUNT,
    CH_DONE
  } ch_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  // Reset to all-ones: a channel leaves ARM only after it has seen a genuine
  // low level, so a pulse that is already high when reset releases can never
  // look like a fresh rising edge while the synchronizer is still filling.
  logic [N_CH-1:0] freq_meta;
  logic [N_CH-1:0] freq_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_meta <= '1;
      freq_sync <= '1;
    end else begin
      freq_meta <= freq;
      freq_sync <= freq_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel pulse-width measurement
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0]   ch_done;
  logic [DATA_W-1:0] ch_val [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_t        st;
    ch_state_t        st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_sat;
    logic [CNT_W-1:0] scaled;
    logic             val_sat;
    logic             ovf_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        st  <= CH_ARM;
        cnt <= '0;
      end else begin
        st  <= st_nxt;
        cnt <= cnt_nxt;
      end
    end

    // finish_send outranks en and any freq edge in the same cycle.
    always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      cnt_sat = 1'b0;
      if (finish_send) begin
        st_nxt  = CH_ARM;
        cnt_nxt = '0;
      end else if (en) begin
        case (st)
          CH_ARM: begin
            if (!freq_sync[g]) st_nxt = CH_WAIT_HI;
          end
          CH_WAIT_HI: begin
            if (freq_sync[g]) begin
              st_nxt  = CH_COUNT;
              cnt_nxt = CNT_W'(1);
            end
          end
          CH_COUNT: begin
            if (!freq_sync[g]) begin
              st_nxt = CH_DONE;
            end else if (&cnt) begin
              cnt_sat = 1'b1;        // hold at all-ones
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          default: begin
            // CH_DONE holds its value until re-armed
          end
        endcase
      end
    end

    // Scaling: anything that does not fit DATA_W after the shift saturates.
    assign scaled    = cnt >> SHIFT;
    assign val_sat   = (scaled >> DATA_W) != '0;
    assign ch_val[g] = val_sat ? {DATA_W{1'b1}} : DATA_W'(scaled);
    assign ch_done[g] = (st == CH_DONE);

    always_ff @(posedge clk) begin
      if (rst || finish_send) begin
        ovf_q <= 1'b0;
      end else if (cnt_sat || val_sat) begin
        ovf_q <= 1'b1;
      end
    end

    assign ovf[g] = ovf_q;
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t          tx_state;
  tx_state_t          tx_nxt;
  logic [2:0]         ch_idx;
  logic [2:0]         idx_nxt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] shreg_nxt;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BAUD_W-1:0]  baud_nxt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_nxt;
  logic               sent;        // round already sent for the current DONE set
  logic               sent_nxt;
  logic               abort;       // finish_send seen during a frame
  logic               abort_nxt;
  logic               done_nxt;
  logic               all_done;
  logic [DATA_W-1:0]  sel_val;
  logic [FRAME_W-1:0] frame;

  assign all_done = &ch_done;
  assign busy     = (tx_state != TX_IDLE);

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_idx == 3'(i)) sel_val = ch_val[i];
    end
  end

  // Frame assembled LSB first so the shift register simply shifts right.
`ifdef PARITY_EN
  assign frame = {1'b1, ^{sel_val, ch_idx}, sel_val, ch_idx, 1'b0};
`else
  assign frame = {1'b1, sel_val, ch_idx, 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      ch_idx   <= '0;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sent     <= 1'b0;
      abort    <= 1'b0;
      done     <= 1'b0;
      sd       <= 1'b1;
    end else begin
      tx_state <= tx_nxt;
      ch_idx   <= idx_nxt;
      shreg    <= shreg_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      sent     <= sent_nxt;
      abort    <= abort_nxt;
      done     <= done_nxt;
      // Registered copy of the bit that will be on the line in the next
      // state, so sd changes exactly on the state transitions, glitch-free.
      sd       <= (tx_nxt == TX_SHIFT) ? shreg_nxt[0] : 1'b1;
    end
  end

  always_comb begin
    tx_nxt    = tx_state;
    idx_nxt   = ch_idx;
    shreg_nxt = shreg;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    sent_nxt  = sent;
    abort_nxt = abort;
    done_nxt  = 1'b0;

    if (finish_send) begin
      sent_nxt = 1'b0;
      if (tx_state != TX_IDLE) abort_nxt = 1'b1;
    end

    case (tx_state)
      TX_IDLE: begin
        if (all_done && en && !sent && !finish_send) begin
          tx_nxt   = TX_LOAD;
          idx_nxt  = '0;
          sent_nxt = 1'b1;
        end
      end

      TX_LOAD: begin
        // Value is frozen here; later count changes do not affect the frame.
        shreg_nxt = frame;
        baud_nxt  = '0;
        bit_nxt   = '0;
        tx_nxt    = TX_SHIFT;
      end

      TX_SHIFT: begin
        if (baud_cnt != BAUD_W'(BAUD_DIV - 1)) begin
          baud_nxt = baud_cnt + 1'b1;
        end else begin
          baud_nxt = '0;
          if (bit_cnt != BIT_W'(FRAME_W - 1)) begin
            bit_nxt   = bit_cnt + 1'b1;
            shreg_nxt = {1'b1, shreg[FRAME_W-1:1]};
          end else begin
            // End of the stop bit.
            tx_nxt    = TX_IDLE;
            abort_nxt = 1'b0;
            if (!(abort || finish_send)) begin
              if (ch_idx == 3'(N_CH - 1)) begin
                done_nxt = 1'b1;
              end else if (!en) begin
                // Disabled mid-round: stop here and resend the whole round
                // from channel 0 once en returns.
                sent_nxt = 1'b0;
              end else begin
                tx_nxt  = TX_LOAD;
                idx_nxt = ch_idx + 1'b1;
              end
            end
          end
        end
      end

      default: tx_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rain_meter_tx.sv
module tb_rain_meter_tx;

  localparam int BAUD = 16;
`ifdef PARITY_EN
  localparam int FW = 1 + 3 + 8 + 1 + 1;
`else
  localparam int FW = 1 + 3 + 8 + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       finish_send;
  logic [1:0] freq;
  logic       sd;
  logic       busy;
  logic       done;
  logic [1:0] ovf;

  rain_meter_tx #(
    .N_CH(2), .CNT_W(16), .DATA_W(8), .SHIFT(0), .BAUD_DIV(BAUD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .finish_send(finish_send), .freq(freq),
    .sd(sd), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp       = 0;
  int   n_fail      = 0;
  int   frames_seen = 0;
  int   done_seen   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input int data);
    exp_t e;
    e.id   = 3'(id);
    e.data = 8'(data);
    exp_q.push_back(e);
  endtask

  // freq[ch] high for exactly len rising edges.
  task automatic pulse(input int ch, input int len);
    @(posedge clk); #1 freq[ch] = 1'b1;
    repeat (len) @(posedge clk);
    #1 freq[ch] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic fs_pulse();
    @(posedge clk); #1 finish_send = 1'b1;
    @(posedge clk); #1 finish_send = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_seen < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frames_received", frames_seen, n);
  endtask

  task automatic wait_busy(input logic lvl);
    int t;
    t = 0;
    while (busy !== lvl && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("busy_reached", busy, lvl);
  endtask

  task automatic wait_sd_low();
    int t;
    t = 0;
    while (sd !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("start_bit_seen", sd, 0);
  endtask

  always @(negedge clk) if (done === 1'b1) done_seen++;

  // Serial receiver + scoreboard: each bit must hold for BAUD samples.
  always begin : mon
    logic [FW-1:0] bits;
    logic          glitch;
    logic          aborted;
    exp_t          e;
    @(negedge clk);
    if (rst === 1'b0 && sd === 1'b0) begin
      bits    = '0;
      glitch  = 1'b0;
      aborted = 1'b0;
      for (int b = 0; b < FW; b++) begin
        for (int c = 0; c < BAUD; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst !== 1'b0) aborted = 1'b1;
          if (c == 0) bits[b] = sd;
          else if (sd !== bits[b]) glitch = 1'b1;
        end
      end
      if (!aborted) begin
        frames_seen++;
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_id", bits[3:1], e.id);
          chk("frame_data", bits[11:4], e.data);
`ifdef PARITY_EN
          chk("frame_parity", bits[12], ^{e.id, e.data});
`endif
        end
        chk("frame_stop", bits[FW-1], 1);
        chk("bit_timing", glitch, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; finish_send = 1'b0; freq = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sd", sd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1 rst = 1'b0; en = 1'b1;

    // 1: basic two-channel round, single done, no resend
    push(0, 8'h28); push(1, 8'hC8);
    pulse(0, 40);
    pulse(1, 200);
    wait_frames(2);
    repeat (300) @(negedge clk);
    chk("t1_no_resend", frames_seen, 2);
    chk("t1_done_once", done_seen, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_ovf", ovf, 0);
    fs_pulse();

    // 2: pulse already high at reset release is ignored
    @(posedge clk); #1 rst = 1'b1; freq[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 freq[0] = 1'b0;
    repeat (3) @(posedge clk);
    push(0, 10); push(1, 5);
    pulse(0, 10);
    pulse(1, 5);
    wait_frames(4);
    repeat (20) @(negedge clk);
    chk("t2_done", done_seen, 2);
    fs_pulse();

    // 3: saturation (300 -> 0xFF with ovf) vs exact fit (255, no ovf)
    push(0, 8'hFF); push(1, 8'hFF);
    pulse(0, 300);
    pulse(1, 255);
    wait_frames(6);
    repeat (20) @(negedge clk);
    chk("t3_ovf_sticky", ovf, 2'b01);
    chk("t3_done", done_seen, 3);
    fs_pulse();
    @(negedge clk);
    chk("t3_ovf_cleared", ovf, 2'b00);

    // 4: finish_send during ch0 frame
    push(0, 12);
    pulse(0, 12);
    pulse(1, 13);
    wait_busy(1'b1);
    repeat (50) @(posedge clk);
    fs_pulse();
    wait_busy(1'b0);
    repeat (300) @(negedge clk);
    chk("t4_only_ch0", frames_seen, 7);
    chk("t4_no_done", done_seen, 3);
    chk("t4_queue_empty", exp_q.size(), 0);
    push(0, 3); push(1, 4);
    pulse(0, 3);
    pulse(1, 4);
    wait_frames(9);
    repeat (20) @(negedge clk);
    chk("t4_rearmed_done", done_seen, 4);
    fs_pulse();

    // 5: reset at bit 5 of a frame
    pulse(0, 20);
    pulse(1, 21);
    wait_sd_low();
    repeat (5 * BAUD + 3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_sd_idle", sd, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ovf", ovf, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (250) @(negedge clk);
    chk("t5_no_partial", frames_seen, 9);
    push(0, 6); push(1, 7);
    pulse(0, 6);
    pulse(1, 7);
    wait_frames(11);
    repeat (20) @(negedge clk);
    fs_pulse();

    // 6: value 0x07 on id 0 (odd ones -> parity 1), minimum 1-cycle pulse
    push(0, 7); push(1, 1);
    pulse(0, 7);
    pulse(1, 1);
    wait_frames(13);
    repeat (20) @(negedge clk);
    chk("t6_done", done_seen, 6);
    fs_pulse();

    // 7: en=0 freezes channels; pulse while disabled is not measured
    @(posedge clk); #1 en = 1'b0;
    pulse(0, 5);
    pulse(1, 5);
    repeat (20) @(negedge clk);
    chk("t7_idle_disabled", busy, 0);
    @(posedge clk); #1 en = 1'b1;
    repeat (4) @(posedge clk);
    push(0, 9); push(1, 2);
    pulse(0, 9);
    pulse(1, 2);
    wait_frames(15);
    repeat (20) @(negedge clk);
    chk("t7_done", done_seen, 7);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
